// File: rtl/vehicle_pkg.sv
// vehicle_pkg: shared state encoding, gear codes and per-gear speed bands for the vehicle plant and gear_set.
package vehicle_pkg;
  typedef enum logic [1:0] {IDLE, FWD, REV, STALL} state_t;
  localparam logic [2:0] GEAR_N   = 3'd0;
  localparam logic [2:0] GEAR_1   = 3'd1;
  localparam logic [2:0] GEAR_R   = 3'd6;
  localparam logic [2:0] GEAR_INV = 3'd7;
  function automatic logic [8:0] gear_cap(input logic [2:0] g, input logic [8:0] v_max);
    case (g)
      3'd1: gear_cap = 9'd25;
      3'd2: gear_cap = 9'd45;
      3'd3: gear_cap = 9'd65;
      3'd4: gear_cap = 9'd85;
      3'd5: gear_cap = v_max;
      3'd6: gear_cap = 9'd15;
      default: gear_cap = 9'd0;
    endcase
  endfunction
  function automatic logic [8:0] gear_min(input logic [2:0] g);
    case (g)
      3'd2: gear_min = 9'd15;
      3'd3: gear_min = 9'd35;
      3'd4: gear_min = 9'd55;
      3'd5: gear_min = 9'd75;
      default: gear_min = 9'd0;
    endcase
  endfunction
endpackage

// File: rtl/vehicle_speed_model_if.sv
// vehicle_speed_model_if: driver controls into the plant, speed/status back out.
interface vehicle_speed_model_if;
  logic       accel;
  logic       brake;
  logic       clutch;
  logic [2:0] gear_in;
  logic [7:0] velocity;
  logic       rev_dir;
  logic       stall;
  logic       shift_err;
  logic       tick;
  modport master (output accel, brake, clutch, gear_in, input velocity, rev_dir, stall, shift_err, tick);
  modport slave  (input accel, brake, clutch, gear_in, output velocity, rev_dir, stall, shift_err, tick);
endinterface

// File: rtl/vehicle_speed_model_prescaler.sv
// tick_prescaler: free-running 0..CLK_DIV-1 counter with a registered one-cycle pulse per wrap.
module tick_prescaler #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;
  always_comb begin
    tick_d = cnt_q == W'(CLK_DIV - 1);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/vehicle_speed_model.sv
// vehicle_speed_model: per-tick speed integrator with gear caps, engine braking, stall and reverse interlock.
module vehicle_speed_model
  import vehicle_pkg::*;
#(
  parameter int CLK_DIV    = 1000,
  parameter int ACCEL_STEP = 1,
  parameter int BRAKE_STEP = 3,
  parameter int DRAG_DIV   = 4,
  parameter int V_MAX      = 120
) (
  input logic clk,
  input logic rst,
  vehicle_speed_model_if.slave bus
);
  localparam int DW = $clog2(DRAG_DIV + 1);
  localparam logic [8:0] ACC9 = 9'(ACCEL_STEP);
  localparam logic [8:0] BRK9 = 9'(BRAKE_STEP);
  logic          tick_w;
  state_t        state_q, state_d, idle_s;
  logic [8:0]    vel_q, vel_d, cap, gmin, dec_b, dec_c, inc, coast_v, move_v, idle_v;
  logic [DW-1:0] drag_q, drag_d;
  logic          rev_q, rev_d, stall_q, stall_d, err_q, err_d;
  logic          inv, eng, fwd_g, rev_g, own, wrong, moving, over, stall_go, coast, start;
  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (.clk(clk), .rst(rst), .tick(tick_w));
  always_comb begin
    inv      = bus.gear_in == GEAR_INV;
    eng      = !bus.clutch && bus.gear_in != GEAR_N && !inv;
    fwd_g    = eng && bus.gear_in != GEAR_R;
    rev_g    = eng && bus.gear_in == GEAR_R;
    cap      = gear_cap(bus.gear_in, 9'(V_MAX));
    gmin     = gear_min(bus.gear_in);
    moving   = state_q == FWD || state_q == REV;
    own      = state_q == REV ? rev_g : fwd_g;
    wrong    = state_q == REV ? fwd_g : rev_g;
    dec_b    = vel_q > BRK9 ? vel_q - BRK9 : 9'd0;
    dec_c    = dec_b < cap ? cap : dec_b;
    inc      = vel_q + ACC9 > cap ? cap : vel_q + ACC9;
    over     = own && vel_q > cap;
    stall_go = state_q == FWD && fwd_g && !bus.brake && vel_q < gmin;
    coast    = !bus.brake && !stall_go && !over && !(bus.accel && own);
    coast_v  = drag_q == DW'(DRAG_DIV - 1) && vel_q != 9'd0 ? vel_q - 9'd1 : vel_q;
    move_v   = bus.brake ? dec_b : stall_go ? vel_q : over ? dec_c : bus.accel && own ? inc : coast_v;
    // Launching in gears 2-5 from standstill lugs the engine straight into a stall.
    start    = bus.accel && !bus.brake && eng;
    idle_s   = !start ? IDLE : bus.gear_in == GEAR_1 ? FWD : rev_g ? REV : STALL;
    idle_v   = start && (bus.gear_in == GEAR_1 || rev_g) ? ACC9 : 9'd0;
    state_d  = state_q;
    vel_d    = vel_q;
    drag_d   = drag_q;
    err_d    = 1'b0;
    if (tick_w) begin
      err_d   = inv || (moving && wrong);
      vel_d   = state_q == IDLE ? idle_v : state_q == STALL ? dec_b : move_v;
      drag_d  = moving && coast ? (drag_q == DW'(DRAG_DIV - 1) ? '0 : drag_q + 1'b1) : '0;
      state_d = state_q == IDLE ? idle_s
              : state_q == STALL ? (vel_q == 9'd0 && (bus.clutch || bus.gear_in == GEAR_N) ? IDLE : STALL)
              : vel_d == 9'd0 ? IDLE : stall_go ? STALL : state_q;
    end
    rev_d   = state_d == REV;
    stall_d = state_d == STALL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vel_q   <= '0;
      drag_q  <= '0;
      rev_q   <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vel_q   <= vel_d;
      drag_q  <= drag_d;
      rev_q   <= rev_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
  assign bus.velocity  = vel_q[7:0];
  assign bus.rev_dir   = rev_q;
  assign bus.stall     = stall_q;
  assign bus.shift_err = err_q;
  assign bus.tick      = tick_w;
endmodule

// File: tb/tb_vehicle_speed_model.sv
// tb_vehicle_speed_model: table-driven tick vectors plus hand-written reset and tick-timing sequences.
module tb_vehicle_speed_model;
  typedef struct {
    int         reps;
    logic       a, b, c;
    logic [2:0] g;
    int         v;
    logic       r, s, e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vehicle_speed_model_if bus ();
  vehicle_speed_model #(.CLK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic a, input logic b, input logic c, input logic [2:0] g);
    bus.accel = a; bus.brake = b; bus.clutch = c; bus.gear_in = g;
  endtask
  task automatic do_tick(input logic a, input logic b, input logic c, input logic [2:0] g);
    int n;
    drive(a, b, c, g);
    n = 0;
    while (!bus.tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tick) chk("tick_timeout", 0, 1);
    @(negedge clk);
  endtask
  function automatic void add(input int reps, input logic a, input logic b, input logic c,
                              input logic [2:0] g, input int v, input logic r, input logic s, input logic e);
    vec_t x;
    x.reps = reps; x.a = a; x.b = b; x.c = c; x.g = g; x.v = v; x.r = r; x.s = s; x.e = e;
    tbl.push_back(x);
  endfunction
  initial begin
    drive(0, 0, 0, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_velocity", int'(bus.velocity), 0);
    chk("reset_rev_dir", int'(bus.rev_dir), 0);
    chk("reset_stall", int'(bus.stall), 0);
    chk("reset_shift_err", int'(bus.shift_err), 0);
    chk("reset_tick", int'(bus.tick), 0);
    repeat (25) do_tick(1, 0, 0, 3'd1);
    repeat (15) do_tick(1, 0, 0, 3'd2);
    chk("drive_to_40", int'(bus.velocity), 40);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_velocity", int'(bus.velocity), 0);
    chk("midrst_tick", int'(bus.tick), 0);
    drive(0, 0, 0, 3'd0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("tick_absent_%0d", i), int'(bus.tick), 0);
    end
    @(negedge clk);
    chk("tick_after_4", int'(bus.tick), 1);
    @(negedge clk);
    chk("after_rst_idle_v", int'(bus.velocity), 0);
    chk("after_rst_rev", int'(bus.rev_dir), 0);
    add(30, 1, 0, 0, 3'd1, 25, 0, 0, 0);
    add(30, 1, 0, 0, 3'd2, 45, 0, 0, 0);
    add(1,  1, 0, 0, 3'd1, 42, 0, 0, 0);
    add(6,  1, 0, 0, 3'd1, 25, 0, 0, 0);
    add(3,  1, 0, 0, 3'd1, 25, 0, 0, 0);
    add(20, 1, 0, 0, 3'd2, 45, 0, 0, 0);
    add(5,  1, 0, 0, 3'd3, 50, 0, 0, 0);
    add(5,  1, 1, 0, 3'd3, 35, 0, 0, 0);
    add(1,  0, 0, 0, 3'd7, 35, 0, 0, 1);
    add(3,  0, 0, 0, 3'd3, 34, 0, 0, 0);
    add(1,  0, 0, 0, 3'd3, 34, 0, 1, 0);
    add(12, 0, 0, 0, 3'd3, 0,  0, 1, 0);
    add(1,  0, 0, 0, 3'd3, 0,  0, 1, 0);
    add(1,  0, 0, 1, 3'd3, 0,  0, 0, 0);
    add(25, 1, 0, 0, 3'd1, 25, 0, 0, 0);
    add(5,  1, 0, 0, 3'd2, 30, 0, 0, 0);
    add(1,  0, 0, 0, 3'd4, 30, 0, 1, 0);
    add(10, 1, 0, 0, 3'd4, 0,  0, 1, 0);
    add(1,  0, 0, 1, 3'd4, 0,  0, 0, 0);
    add(20, 1, 0, 0, 3'd6, 15, 1, 0, 0);
    add(1,  1, 0, 0, 3'd2, 15, 1, 0, 1);
    add(3,  0, 0, 0, 3'd6, 14, 1, 0, 0);
    add(5,  0, 1, 0, 3'd6, 0,  0, 0, 0);
    add(1,  1, 0, 0, 3'd2, 0,  0, 1, 0);
    add(1,  0, 0, 0, 3'd0, 0,  0, 0, 0);
    add(1,  1, 0, 1, 3'd1, 0,  0, 0, 0);
    add(1,  1, 1, 0, 3'd1, 0,  0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].reps) do_tick(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].g);
      chk($sformatf("row%0d_velocity", i), int'(bus.velocity), tbl[i].v);
      chk($sformatf("row%0d_rev_dir", i), int'(bus.rev_dir), int'(tbl[i].r));
      chk($sformatf("row%0d_stall", i), int'(bus.stall), int'(tbl[i].s));
      chk($sformatf("row%0d_shift_err", i), int'(bus.shift_err), int'(tbl[i].e));
    end
    do_tick(0, 0, 0, 3'd7);
    chk("idle_inv_err", int'(bus.shift_err), 1);
    @(negedge clk);
    chk("err_one_clk", int'(bus.shift_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
